// File: rtl/joy_socd_filter.sv
// Joystick direction conditioner: sync, debounce, SOCD last-press-wins, 2/4/8-way restriction.
// Latency: 3 cycles input edge to dir_out with DEB_CNT=0, 3+DEB_CNT cycles otherwise.
// Backpressure: none; free-running, one result per clk per channel.
//
// Ports:
//   clk       system clock
//   I_RESETn  synchronous active-low reset
//   mode      0=2-way H, 1=2-way V, 2=4-way, 3=8-way (all channels)
//   dir_in    raw directions, nibble per channel {U,D,L,R}, active high
//   dir_out   resolved directions, same packing, registered
//   changed   one-cycle pulse per channel when its dir_out nibble changes

module joy_socd_filter #(
  parameter int CHANNELS = 2,
  parameter int DEB_W    = 16,
  parameter int DEB_CNT  = 24000
) (
  input  logic                  clk,
  input  logic                  I_RESETn,
  input  logic [1:0]            mode,
  input  logic [4*CHANNELS-1:0] dir_in,
  output logic [4*CHANNELS-1:0] dir_out,
  output logic [CHANNELS-1:0]   changed
);

  localparam int NB = 4 * CHANNELS;

  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] w_stable;
  logic [NB-1:0] r_stable_q;
  logic [NB-1:0] w_rise;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (!I_RESETn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= dir_in;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEB_CNT == 0) begin : g_nodeb
      assign w_stable = r_sync2;
    end else begin : g_deb
      localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

      logic [NB-1:0]    r_deb;
      logic [DEB_W-1:0] r_cnt [NB];

      // A bit only flips after DEB_CNT consecutive mismatching cycles; any
      // agreeing cycle restarts the count, so short glitches are swallowed.
      always_ff @(posedge clk) begin
        if (!I_RESETn) begin
          r_deb <= '0;
          for (int b = 0; b < NB; b++) r_cnt[b] <= '0;
        end else begin
          for (int b = 0; b < NB; b++) begin
            if (r_sync2[b] == r_deb[b]) begin
              r_cnt[b] <= '0;
            end else if (r_cnt[b] == CNT_LAST) begin
              r_deb[b] <= r_sync2[b];
              r_cnt[b] <= '0;
            end else begin
              r_cnt[b] <= r_cnt[b] + DEB_W'(1);
            end
          end
        end
      end

      assign w_stable = r_deb;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!I_RESETn) r_stable_q <= '0;
    else           r_stable_q <= w_stable;
  end

  assign w_rise = w_stable & ~r_stable_q;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [3:0] w_s;
      logic [3:0] w_r;
      logic [1:0] r_last_h;
      logic [1:0] r_last_v;
      logic       r_last_axis;
      logic [1:0] w_nlh;
      logic [1:0] w_nlv;
      logic       w_nla;
      logic [1:0] w_h;
      logic [1:0] w_v;
      logic [3:0] w_nib;
      logic [3:0] r_dir;
      logic       r_chg;

      assign w_s = w_stable[4*c +: 4];
      assign w_r = w_rise[4*c +: 4];

      // Most recent press on each axis; the second direction in the pair
      // (L, U) wins a same-cycle tie.
      assign w_nlh = w_r[1] ? 2'b10 : (w_r[0] ? 2'b01 : r_last_h);
      assign w_nlv = w_r[3] ? 2'b10 : (w_r[2] ? 2'b01 : r_last_v);
      // Most recently touched axis; horizontal wins a same-cycle tie.
      assign w_nla = (w_r[0] | w_r[1]) ? 1'b0 :
                     ((w_r[2] | w_r[3]) ? 1'b1 : r_last_axis);

      // Opposing pair held: use the updated last-press so a press this
      // cycle is honoured immediately.
      assign w_h = (w_s[0] & w_s[1]) ? w_nlh : {w_s[1], w_s[0]};
      assign w_v = (w_s[2] & w_s[3]) ? w_nlv : {w_s[3], w_s[2]};

      always_comb begin
        w_nib = 4'b0000;
        case (mode)
          2'd0: w_nib = {2'b00, w_h};
          2'd1: w_nib = {w_v, 2'b00};
          2'd2: begin
            if ((w_h != 2'b00) && (w_v != 2'b00))
              w_nib = w_nla ? {w_v, 2'b00} : {2'b00, w_h};
            else
              w_nib = {w_v, w_h};
          end
          default: w_nib = {w_v, w_h};
        endcase
      end

      always_ff @(posedge clk) begin
        if (!I_RESETn) begin
          r_last_h    <= 2'b00;
          r_last_v    <= 2'b00;
          r_last_axis <= 1'b0;
          r_dir       <= 4'b0000;
          r_chg       <= 1'b0;
        end else begin
          r_last_h    <= w_nlh;
          r_last_v    <= w_nlv;
          r_last_axis <= w_nla;
          r_dir       <= w_nib;
          r_chg       <= (w_nib != r_dir);
        end
      end

      assign dir_out[4*c +: 4] = r_dir;
      assign changed[c]        = r_chg;
    end
  endgenerate

endmodule

// File: tb/tb_joy_socd_filter.sv
// Bench for joy_socd_filter: one instance without debounce, one with DEB_CNT=4.
// Expected nibbles are queued with a due cycle when stimulus is driven and
// compared at the falling edge of that cycle.

module tb_joy_socd_filter;

  logic       clk = 1'b0;
  logic       rst_n0, rst_n4;
  logic [1:0] mode0, mode4;
  logic [7:0] din0, din4;
  logic [7:0] dout0, dout4;
  logic [1:0] chg0, chg4;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  joy_socd_filter #(.CHANNELS(2), .DEB_W(16), .DEB_CNT(0)) u_dut0 (
    .clk(clk), .I_RESETn(rst_n0), .mode(mode0),
    .dir_in(din0), .dir_out(dout0), .changed(chg0)
  );

  joy_socd_filter #(.CHANNELS(2), .DEB_W(8), .DEB_CNT(4)) u_dut4 (
    .clk(clk), .I_RESETn(rst_n4), .mode(mode4),
    .dir_in(din4), .dir_out(dout4), .changed(chg4)
  );

  typedef struct {
    int         due;
    int         dut;
    int         ch;
    logic [3:0] dir;
    logic       chg;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int dly, input int dut, input int ch,
                          input logic [3:0] dir, input logic chg, input string tag);
    exp_t e;
    e.due = cyc + dly;
    e.dut = dut;
    e.ch  = ch;
    e.dir = dir;
    e.chg = chg;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard drain: every entry that has come due is compared and removed.
  always @(negedge clk) begin
    int         i;
    logic [3:0] a_dir;
    logic       a_chg;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due <= cyc) begin
        if (sb_q[i].dut == 0) begin
          a_dir = dout0[sb_q[i].ch*4 +: 4];
          a_chg = chg0[sb_q[i].ch];
        end else begin
          a_dir = dout4[sb_q[i].ch*4 +: 4];
          a_chg = chg4[sb_q[i].ch];
        end
        chk({tag_q[i], "_dir"}, 32'(a_dir), 32'(sb_q[i].dir));
        chk({tag_q[i], "_chg"}, 32'(a_chg), 32'(sb_q[i].chg));
        sb_q.delete(i);
        tag_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n0 = 1'b0; rst_n4 = 1'b0;
    mode0  = 2'd3; mode4  = 2'd3;
    din0   = '0;   din4   = '0;
    step(3);
    for (int c = 0; c < 2; c++) begin
      push_exp(0, 0, c, 4'b0000, 1'b0, "rst0");
      push_exp(0, 1, c, 4'b0000, 1'b0, "rst4");
    end
    step(1);
    rst_n0 = 1'b1; rst_n4 = 1'b1;
    step(3);

    // 8-way, no debounce: R pressed -> output 3 cycles later, single pulse.
    din0 = 8'b0000_0001;
    push_exp(2, 0, 0, 4'b0000, 1'b0, "lat_pre");
    push_exp(3, 0, 0, 4'b0001, 1'b1, "lat_r");
    push_exp(4, 0, 0, 4'b0001, 1'b0, "lat_hold");
    push_exp(8, 0, 0, 4'b0001, 1'b0, "lat_hold2");
    step(10);
    din0 = 8'b0;
    push_exp(3, 0, 0, 4'b0000, 1'b1, "rel_r");
    step(6);

    // 2-way horizontal: last press wins, release falls back.
    mode0 = 2'd0;
    din0 = 8'b0000_0001;
    push_exp(3, 0, 0, 4'b0001, 1'b1, "h_r");
    step(10);
    din0 = 8'b0000_0011;
    push_exp(3, 0, 0, 4'b0010, 1'b1, "h_rl");
    step(5);
    din0 = 8'b0000_0001;
    push_exp(3, 0, 0, 4'b0001, 1'b1, "h_rel_l");
    step(5);
    din0 = 8'b0;
    step(5);
    rst_n0 = 1'b0;
    push_exp(1, 0, 0, 4'b0000, 1'b0, "h_rst");
    step(1);
    rst_n0 = 1'b1;
    din0 = 8'b0000_0011;
    push_exp(3, 0, 0, 4'b0010, 1'b1, "h_both");
    step(5);
    din0 = 8'b0;
    step(5);

    // 4-way: newest axis kept; simultaneous press favours horizontal.
    mode0 = 2'd2;
    din0 = 8'b0000_0001;
    push_exp(3, 0, 0, 4'b0001, 1'b1, "w4_r");
    step(5);
    din0 = 8'b0000_1001;
    push_exp(3, 0, 0, 4'b1000, 1'b1, "w4_ru");
    step(5);
    din0 = 8'b0000_0001;
    push_exp(3, 0, 0, 4'b0001, 1'b1, "w4_rel_u");
    step(5);
    din0 = 8'b0;
    step(5);
    din0 = 8'b0000_1001;
    push_exp(3, 0, 0, 4'b0001, 1'b1, "w4_same");
    step(5);
    din0 = 8'b0;
    step(5);

    // 2-way vertical, then live switch to 8-way.
    mode0 = 2'd1;
    din0 = 8'b0000_1001;
    push_exp(3, 0, 0, 4'b1000, 1'b1, "v_ru");
    step(5);
    mode0 = 2'd3;
    push_exp(1, 0, 0, 4'b1001, 1'b1, "m3_sw");
    push_exp(2, 0, 0, 4'b1001, 1'b0, "m3_hold");
    step(3);

    // Channel 1 activity must not disturb channel 0.
    din0 = 8'b0001_1001;
    push_exp(3, 0, 1, 4'b0001, 1'b1, "ch1_r");
    push_exp(3, 0, 0, 4'b1001, 1'b0, "ch0_iso");
    push_exp(4, 0, 0, 4'b1001, 1'b0, "ch0_iso2");
    step(6);

    // Debounced instance: short pulse rejected.
    din4 = 8'b0000_0010;
    push_exp(3, 1, 0, 4'b0000, 1'b0, "glitch_a");
    push_exp(7, 1, 0, 4'b0000, 1'b0, "glitch_b");
    push_exp(10, 1, 0, 4'b0000, 1'b0, "glitch_c");
    step(3);
    din4 = 8'b0;
    step(10);

    // Held L appears 3+DEB_CNT cycles later.
    din4 = 8'b0000_0010;
    push_exp(6, 1, 0, 4'b0000, 1'b0, "deb_pre");
    push_exp(7, 1, 0, 4'b0010, 1'b1, "deb_l");
    push_exp(8, 1, 0, 4'b0010, 1'b0, "deb_hold");
    step(10);

    // Reset with L resolved and still held: cleared, then re-acquired.
    rst_n4 = 1'b0;
    push_exp(1, 1, 0, 4'b0000, 1'b0, "rst_l");
    step(1);
    rst_n4 = 1'b1;
    push_exp(6, 1, 0, 4'b0000, 1'b0, "rst_l_pre");
    push_exp(7, 1, 0, 4'b0010, 1'b1, "rst_l_back");
    step(10);
    din4 = 8'b0;
    step(12);

    // Reset mid-debounce on R discards the partial count.
    din4 = 8'b0000_0001;
    step(4);
    rst_n4 = 1'b0;
    push_exp(1, 1, 0, 4'b0000, 1'b0, "rst_mid");
    step(1);
    rst_n4 = 1'b1;
    push_exp(6, 1, 0, 4'b0000, 1'b0, "rst_mid_pre");
    push_exp(7, 1, 0, 4'b0001, 1'b1, "rst_mid_r");
    push_exp(8, 1, 0, 4'b0001, 1'b0, "rst_mid_hold");
    step(12);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
